// File: rtl/pc_pkg.sv
// Shared constants and the next-PC select encoding for the fetch sequencer.
package pc_pkg;

   localparam int unsigned DEFAULT_WIDTH        = 32;
   localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h3000;
   localparam int unsigned DEFAULT_RAS_DEPTH    = 4;

   // Pseudo-direct jumps replace the low 28 bits of pc_plus4.
   localparam int unsigned REGION_BITS = 28;

   typedef enum logic [2:0] {
      SEQ,
      BRANCH,
      RET,
      JREG,
      JUMP,
      HOLD
   } pc_sel_e;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack. A push onto a full stack overwrites the
// oldest entry and sets the sticky overflow flag.
module ras_stack #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic             replace,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] top,
   output logic             empty,
   output logic             full,
   output logic             overflow
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] ptr_q, ptr_d;   // index of the current top entry
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic             wr_en;
   logic [PTR_W-1:0] wr_idx;

   assign top      = mem_q[ptr_q];
   assign empty    = (cnt_q == '0);
   assign full     = (cnt_q == CNT_MAX);
   assign overflow = ovf_q;

   // Pointer/count/flag next state and entry write selection.
   always_comb begin
      ptr_d  = ptr_q;
      cnt_d  = cnt_q;
      ovf_d  = ovf_q;
      wr_en  = 1'b0;
      wr_idx = ptr_q;
      if (push) begin
         ptr_d  = ptr_q + PTR_W'(1);
         wr_en  = 1'b1;
         wr_idx = ptr_q + PTR_W'(1);
         if (full) begin
            ovf_d = 1'b1;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end else if (replace) begin
         wr_en  = 1'b1;
         wr_idx = ptr_q;
      end else if (pop && !empty) begin
         ptr_d = ptr_q - PTR_W'(1);
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   // Control state; reset discards the stack without clearing entries.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
      end
   end

   // Entry storage, no reset needed.
   always_ff @(posedge clk) begin
      if (!rst && wr_en) begin
         mem_q[wr_idx] <= wdata;
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-address sequencer: selects the next PC from stall, branch, return,
// register jump, pseudo-direct jump or sequential flow, and manages the RAS.
module pc_sequencer
   import pc_pkg::*;
#(
   parameter int unsigned     WIDTH        = DEFAULT_WIDTH,
   parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEFAULT_RESET_VECTOR),
   parameter int unsigned     RAS_DEPTH    = DEFAULT_RAS_DEPTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             branch_taken,
   input  logic [WIDTH-1:0] branch_offset,
   input  logic             jump,
   input  logic [25:0]      jump_target,
   input  logic             jump_reg,
   input  logic [WIDTH-1:0] reg_target,
   input  logic             call,
   input  logic             ret,
   output logic [WIDTH-1:0] pc_out,
   output logic [WIDTH-1:0] pc_plus4,
   output logic             ras_empty,
   output logic             ras_full,
   output logic             ret_miss,
   output logic             ras_overflow
);

   // Keeps only the bits above the pseudo-direct region.
   localparam logic [WIDTH-1:0] REGION_KEEP = ~WIDTH'({REGION_BITS{1'b1}});

   logic [WIDTH-1:0] pc_q, pc_d;
   logic             miss_q, miss_d;
   pc_sel_e          sel;
   logic             ras_push, ras_pop, ras_replace;
   logic [WIDTH-1:0] ras_top;
   logic [WIDTH-1:0] branch_addr, jump_addr, jreg_addr;

   assign pc_out   = pc_q;
   assign ret_miss = miss_q;
   assign pc_plus4 = pc_q + WIDTH'(4);

   assign branch_addr = pc_plus4 + (branch_offset << 2);
   assign jump_addr   = (pc_plus4 & REGION_KEEP) | WIDTH'({jump_target, 2'b00});
   assign jreg_addr   = reg_target & ~WIDTH'(3);

   // Priority select plus stack operation for this cycle.
   always_comb begin
      sel         = SEQ;
      ras_push    = 1'b0;
      ras_pop     = 1'b0;
      ras_replace = 1'b0;
      miss_d      = 1'b0;
      if (stall) begin
         sel = HOLD;
      end else if (branch_taken) begin
         sel = BRANCH;
      end else if (ret) begin
         if (ras_empty) begin
            sel      = SEQ;
            miss_d   = 1'b1;
            ras_push = call && jump_reg;
         end else begin
            sel = RET;
            // A return that is also a register call swaps the top link.
            if (call && jump_reg) begin
               ras_replace = 1'b1;
            end else begin
               ras_pop = 1'b1;
            end
         end
      end else if (jump_reg) begin
         sel      = JREG;
         ras_push = call;
      end else if (jump) begin
         sel      = JUMP;
         ras_push = call;
      end
   end

   // Next-PC mux.
   always_comb begin
      pc_d = pc_q;
      case (sel)
         SEQ:     pc_d = pc_plus4;
         BRANCH:  pc_d = branch_addr;
         RET:     pc_d = ras_top;
         JREG:    pc_d = jreg_addr;
         JUMP:    pc_d = jump_addr;
         default: pc_d = pc_q;
      endcase
   end

   // PC and return-miss pulse registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q   <= RESET_VECTOR;
         miss_q <= 1'b0;
      end else begin
         pc_q   <= pc_d;
         miss_q <= miss_d;
      end
   end

   ras_stack #(
      .WIDTH (WIDTH),
      .DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk      (clk),
      .rst      (rst),
      .push     (ras_push),
      .pop      (ras_pop),
      .replace  (ras_replace),
      .wdata    (pc_plus4),
      .top      (ras_top),
      .empty    (ras_empty),
      .full     (ras_full),
      .overflow (ras_overflow)
   );

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: each step pushes the expected registered
// state to a scoreboard queue, clocks once, and compares on the falling edge.
module tb_pc_sequencer;

   localparam int unsigned OP_RST  = 1;
   localparam int unsigned OP_STL  = 2;
   localparam int unsigned OP_BR   = 4;
   localparam int unsigned OP_J    = 8;
   localparam int unsigned OP_JR   = 16;
   localparam int unsigned OP_CALL = 32;
   localparam int unsigned OP_RET  = 64;

   typedef struct packed {
      logic [31:0] pc;
      logic        empty;
      logic        full;
      logic        miss;
      logic        ovf;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_offset = '0;
   logic        jump = 1'b0;
   logic [25:0] jump_target = '0;
   logic        jump_reg = 1'b0;
   logic [31:0] reg_target = '0;
   logic        call = 1'b0;
   logic        ret = 1'b0;
   logic [31:0] pc_out, pc_plus4;
   logic        ras_empty, ras_full, ret_miss, ras_overflow;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   step_no  = 0;

   pc_sequencer dut (
      .clk           (clk),
      .rst           (rst),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_offset (branch_offset),
      .jump          (jump),
      .jump_target   (jump_target),
      .jump_reg      (jump_reg),
      .reg_target    (reg_target),
      .call          (call),
      .ret           (ret),
      .pc_out        (pc_out),
      .pc_plus4      (pc_plus4),
      .ras_empty     (ras_empty),
      .ras_full      (ras_full),
      .ret_miss      (ret_miss),
      .ras_overflow  (ras_overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         $display("FAIL %s: got %h, expected %h", tag, act, exp);
      end else begin
         n_pass++;
      end
   endtask

   // Drive one cycle of controls, queue the expected state, then compare.
   task automatic step(input int unsigned ops, input logic [31:0] data,
                       input logic [31:0] e_pc, input logic [3:0] e_flags);
      exp_t e;
      exp_t got;
      rst           = (ops & OP_RST) != 0;
      stall         = (ops & OP_STL) != 0;
      branch_taken  = (ops & OP_BR) != 0;
      jump          = (ops & OP_J) != 0;
      jump_reg      = (ops & OP_JR) != 0;
      call          = (ops & OP_CALL) != 0;
      ret           = (ops & OP_RET) != 0;
      branch_offset = data;
      jump_target   = data[25:0];
      reg_target    = data;
      e.pc    = e_pc;
      e.empty = e_flags[3];
      e.full  = e_flags[2];
      e.miss  = e_flags[1];
      e.ovf   = e_flags[0];
      sb_q.push_back(e);
      @(posedge clk);
      @(negedge clk);
      step_no++;
      if (sb_q.size() == 0) begin
         check($sformatf("s%0d.scoreboard", step_no), 32'd0, 32'd1);
      end else begin
         got = sb_q.pop_front();
         check($sformatf("s%0d.pc", step_no), pc_out, got.pc);
         check($sformatf("s%0d.pc_plus4", step_no), pc_plus4, got.pc + 32'd4);
         check($sformatf("s%0d.ras_empty", step_no), 32'(ras_empty), 32'(got.empty));
         check($sformatf("s%0d.ras_full", step_no), 32'(ras_full), 32'(got.full));
         check($sformatf("s%0d.ret_miss", step_no), 32'(ret_miss), 32'(got.miss));
         check($sformatf("s%0d.ras_overflow", step_no), 32'(ras_overflow), 32'(got.ovf));
      end
   endtask

   // Flags are {empty, full, miss, ovf}.
   initial begin
      @(negedge clk);
      step(OP_RST, 0, 32'h3000, 4'b1000);
      step(0, 0, 32'h3004, 4'b1000);
      step(0, 0, 32'h3008, 4'b1000);
      step(0, 0, 32'h300C, 4'b1000);
      // Branch -2 from 0x3004, first blocked by stall.
      step(OP_RST, 0, 32'h3000, 4'b1000);
      step(0, 0, 32'h3004, 4'b1000);
      step(OP_STL | OP_BR, 32'hFFFF_FFFE, 32'h3004, 4'b1000);
      step(OP_BR, 32'hFFFF_FFFE, 32'h3000, 4'b1000);
      step(0, 0, 32'h3004, 4'b1000);
      step(0, 0, 32'h3008, 4'b1000);
      step(0, 0, 32'h300C, 4'b1000);
      step(0, 0, 32'h3010, 4'b1000);
      // Pseudo-direct call and return.
      step(OP_J | OP_CALL, 32'h0000400, 32'h1000, 4'b0000);
      step(0, 0, 32'h1004, 4'b0000);
      step(OP_RET, 0, 32'h3014, 4'b1000);
      // Return on empty stack loses to a taken branch: 0x3018 + 0x10.
      step(OP_RET | OP_BR, 32'd4, 32'h3028, 4'b1000);
      step(0, 0, 32'h302C, 4'b1000);
      // Five calls into a 4-deep stack: links 3030, 4004, 5004, 6004, 7004.
      step(OP_JR | OP_CALL, 32'h4000, 32'h4000, 4'b0000);
      step(OP_JR | OP_CALL, 32'h5000, 32'h5000, 4'b0000);
      step(OP_J | OP_CALL, 32'h1800, 32'h6000, 4'b0000);
      step(OP_JR | OP_CALL, 32'h7000, 32'h7000, 4'b0100);
      step(OP_JR | OP_CALL, 32'h8001, 32'h8000, 4'b0101);
      step(OP_RET, 0, 32'h7004, 4'b0001);
      step(OP_RET, 0, 32'h6004, 4'b0001);
      step(OP_RET, 0, 32'h5004, 4'b0001);
      step(OP_RET, 0, 32'h4004, 4'b1001);
      step(OP_RET, 0, 32'h4008, 4'b1011);
      step(0, 0, 32'h400C, 4'b1001);
      // Return combined with a register call swaps the top link.
      step(OP_JR | OP_CALL, 32'h9000, 32'h9000, 4'b0001);
      step(OP_RET | OP_JR | OP_CALL, 32'hA000, 32'h4010, 4'b0001);
      step(OP_RET, 0, 32'h9004, 4'b1001);
      step(OP_CALL, 0, 32'h9008, 4'b1001);
      // Wrap modulo 2^32.
      step(OP_JR, 32'hFFFF_FFFE, 32'hFFFF_FFFC, 4'b1001);
      step(0, 0, 32'h0000_0000, 4'b1001);
      // Reset during stall discards the stack and clears overflow.
      step(OP_JR | OP_CALL, 32'h0100, 32'h0100, 4'b0001);
      step(OP_RST | OP_STL | OP_RET, 0, 32'h3000, 4'b1000);
      step(OP_RET, 0, 32'h3004, 4'b1010);
      step(0, 0, 32'h3008, 4'b1000);
      check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, PC width in bits (>= 28).
REQ-002 SHALL have parameter RESET_VECTOR, default 32'h3000, first fetch address after reset.
REQ-003 SHALL have parameter RAS_DEPTH, default 4, return-address-stack entries (power of two, >= 2).
REQ-004 SHALL have port clk, input, 1, single clock; all state updates on posedge.
REQ-005 SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-006 SHALL have port stall, input, 1, hold PC and stack this cycle.
REQ-007 SHALL have port branch_taken, input, 1, take PC-relative branch.
REQ-008 SHALL have port branch_offset, input, WIDTH, signed word offset.
REQ-009 SHALL have port jump, input, 1, take pseudo-direct jump.
REQ-010 SHALL have port jump_target, input, 26, word index of jump target.
REQ-011 SHALL have port jump_reg, input, 1, take register-indirect jump.
REQ-012 SHALL have port reg_target, input, WIDTH, byte address for jump_reg.
REQ-013 SHALL have port call, input, 1, qualifies jump/jump_reg as a call (push link).
REQ-014 SHALL have port ret, input, 1, return: pop stack and redirect.
REQ-015 SHALL have port pc_out, output, WIDTH, current fetch address (registered).
REQ-016 SHALL have port pc_plus4, output, WIDTH, pc_out+4 (combinational).
REQ-017 SHALL have ports ras_empty, ras_full, output, 1 each, stack occupancy 0 / RAS_DEPTH.
REQ-018 SHALL have port ret_miss, output, 1, registered one-cycle pulse: ret accepted on empty stack.
REQ-019 SHALL have port ras_overflow, output, 1, sticky: a push hit a full stack.

Function
REQ-020 SHALL select next PC by priority: stall > branch_taken > ret > jump_reg > jump > sequential.
REQ-021 Stall SHALL hold pc_out, stack, count and flags; all other controls are ignored; ret_miss SHALL be 0 that cycle.
REQ-022 Sequential: next = pc_out + 4.
REQ-023 Branch: next = pc_out + 4 + (branch_offset << 2), modulo 2^WIDTH; call/ret ignored.
REQ-024 Jump: next = {pc_plus4[WIDTH-1:28], jump_target, 2'b00}.
REQ-025 Jump_reg: next = reg_target with bits [1:0] forced to 0.
REQ-026 Call with taken jump or jump_reg SHALL push pc_plus4; call alone SHALL have no effect.
REQ-027 Ret on non-empty stack: next = top entry; pop; latency one cycle, pc_out shows target the following cycle.
REQ-028 Ret on empty stack: next = pc_out + 4, stack unchanged, ret_miss pulses next cycle.
REQ-029 Push when full SHALL overwrite the oldest entry (circular), count stays RAS_DEPTH, ras_overflow set.
REQ-030 Ret with call and jump_reg both asserted: ret wins the PC select; stack SHALL replace top with pc_plus4, count unchanged (an empty stack performs a push instead).
REQ-031 All PC arithmetic SHALL wrap modulo 2^WIDTH without flags.

Reset
REQ-032 rst SHALL override stall and all controls on the clock edge.
REQ-033 Reset values: pc_out = RESET_VECTOR, count = 0, ras_empty = 1, ras_full = 0, ret_miss = 0, ras_overflow = 0.
REQ-034 Reset mid-operation SHALL discard all stack contents; entry data need not be cleared.

Structure
REQ-035 Package pc_pkg SHALL hold default WIDTH/RESET_VECTOR/RAS_DEPTH constants and the next-PC select enum (SEQ, BRANCH, RET, JREG, JUMP, HOLD).
REQ-036 Stack SHALL be sub-module ras_stack (push, pop, replace, top, count, empty, full, overflow); the select/adder logic stays in pc_sequencer.

Verification
REQ-037 Reset, then 3 idle cycles -> pc_out 0x3000, 0x3004, 0x3008, 0x300C.
REQ-038 At pc 0x3004 branch_taken, offset -2 -> pc_out 0x3000; same cycle with stall -> pc_out stays 0x3004.
REQ-039 At pc 0x3010 jump+call, target 0x0000400 -> pc_out 0x1000, top = 0x3014; later ret -> pc_out 0x3014, ras_empty = 1.
REQ-040 Five calls at RAS_DEPTH 4 (links A..E) -> ras_full, ras_overflow = 1; four rets -> E, D, C, B; fifth ret -> pc+4, ret_miss pulse.
REQ-041 Ret on empty stack with branch_taken -> branch target taken, ret_miss stays 0; rst asserted during stall -> pc_out 0x3000 next cycle.
